mk_test_udp_ip_arp_eth_cmac_rx_tx: RTL and testbench
====================================================

MK_TEST_UDP_IP_ARP_ETH_CMAC_RX_TX -- requirements
Module: mk_test_udp_ip_arp_eth_cmac_rx_tx

Interface
REQ-001 SHALL have parameter PKT_NUM, default 64: number of test packets sent and checked.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4: maximum packets sent but not yet fully received.
REQ-003 SHALL have input udp_clk, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have input udp_reset, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have these config outputs: m_udp_config_valid (1), m_udp_config_mac_addr (48), m_udp_config_ip_addr (32), m_udp_config_net_mask (32), m_udp_config_gate_way (32); and input m_udp_config_ready (1).
REQ-006 SHALL have these TX meta outputs: m_udp_meta_valid (1), m_udp_meta_ip_addr (32), m_udp_meta_ip_dscp (6), m_udp_meta_ip_ecn (2), m_udp_meta_dst_port (16), m_udp_meta_src_port (16), m_udp_meta_data_len (16); and input m_udp_meta_ready (1).
REQ-007 SHALL have these TX stream outputs: m_data_stream_tvalid (1), m_data_stream_tdata (256), m_data_stream_tkeep (32), m_data_stream_tfirst (1), m_data_stream_tlast (1); and input m_data_stream_tready (1).
REQ-008 SHALL have these RX meta inputs: s_udp_meta_valid plus the same fields and widths as REQ-006 (s_ prefix); and output s_udp_meta_ready (1).
REQ-009 SHALL have these RX stream inputs: s_data_stream_tvalid, tdata (256), tkeep (32), tfirst, tlast (s_ prefix); and output s_data_stream_tready (1).

Function
REQ-010 SHALL transfer data on any channel only in a cycle where valid=1 and ready=1; once valid is asserted, valid and payload SHALL stay stable until that handshake.
REQ-011 SHALL run a TX state machine with states IDLE, CONFIG, META, DATA and DONE: IDLE->CONFIG one cycle after reset release; CONFIG->META on config handshake; META->DATA on meta handshake; DATA->META on a tlast handshake while more packets remain, otherwise DATA->DONE.
REQ-012 SHALL drive these config values: mac 48'hD89C_679B_E3AA, ip 32'hC0A8_0001, mask 32'hFFFF_FF00, gateway 32'hC0A8_00FE; config SHALL be sent exactly once.
REQ-013 SHALL form packet i (0..PKT_NUM-1) as follows: ip_addr = own ip (loopback); dscp 0; ecn 0; dst_port 16'h12B7; src_port = i[15:0]; data_len L(i) = ((i mod 64)+1)*7 bytes.
REQ-014 SHALL NOT assert m_udp_meta_valid while (tx_count - rx_count) >= MAX_OUTSTANDING.
REQ-015 SHALL send each payload as ceil(L/32) beats: tfirst=1 on beat 0 only; tlast=1 on the final beat only.
REQ-016 SHALL set tkeep to all ones on every beat except the final one; on the final beat the low (L mod 32) bits SHALL be 1, or all 32 bits if L mod 32 = 0.
REQ-017 SHALL set byte lane j of beat b to (i + 32b + j) mod 256; bytes not kept SHALL be 0.
REQ-018 SHALL hold s_udp_meta_ready and s_data_stream_tready at 1 whenever out of reset.
REQ-019 SHALL keep an independent RX packet index r and regenerate the expected packet r from it; RX meta SHALL be compared field by field, with the expected ip_addr being own ip.
REQ-020 SHALL check each RX beat against the expected tfirst, tlast and tkeep, and compare tdata on kept bytes only; r SHALL increment on the tlast handshake.
REQ-021 SHALL check that the beat count equals ceil(L/32); an early or missing tlast SHALL count as one error and resynchronise r on the next tfirst.
REQ-022 SHALL increment a 16-bit saturating error counter once per mismatching handshake; it SHALL reach DONE-pass when r == PKT_NUM with 0 errors.
REQ-023 SHALL handle a meta and a data handshake in the same cycle independently.

Reset
REQ-024 SHALL, while udp_reset=0, force all valid outputs and both RX ready outputs to 0, tdata/tkeep/tfirst/tlast to 0, all counters to 0 and the state to IDLE.
REQ-025 SHALL, on reset asserted mid-operation, abandon the test; after release it SHALL restart from CONFIG.

Configuration
REQ-026 SHALL use macro TEST_REPORT_EN: when it is defined, each mismatch SHALL $display the packet index, field, expected and actual values, and reaching DONE SHALL print PASS or FAIL then $finish; when it is undefined, no simulation tasks are present and the logic is fully synthesizable and idles in DONE.

Verification
REQ-027 SHALL cover: reset release, config_ready=1 -> config valid one cycle after IDLE with the REQ-012 values, then exactly one handshake.
REQ-028 SHALL cover: packet 4 (L=35) -> 2 beats; beat1 tkeep=32'h0000_0007; byte0 of beat1 = 8'h24.
REQ-029 SHALL cover: m_udp_meta_ready held 0 -> meta valid stays high and stable; no data beats are sent.
REQ-030 SHALL cover: ideal loopback of all PKT_NUM=64 packets -> error count 0 and PASS.
REQ-031 SHALL cover: one RX data byte corrupted in packet 10 -> error count 1 and FAIL.
REQ-032 SHALL cover: RX path stalled -> at most 4 metas sent; udp_reset pulsed mid-packet -> all outputs reset and config resent.

Source files
------------

// File: rtl/mk_test_udp_ip_arp_eth_cmac_rx_tx.sv
// mk_test_udp_ip_arp_eth_cmac_rx_tx
// Loopback traffic generator and checker for a UDP/IP/ARP/Ethernet stack.
// TX side configures the stack once, then sends PKT_NUM numbered packets.
// The number of packets in flight is limited to MAX_OUTSTANDING.
// RX side regenerates every expected packet from its own index and counts mismatches.
// Optional macro TEST_REPORT_EN adds simulation-only mismatch reports, plus PASS/FAIL and $finish at the end.
module mk_test_udp_ip_arp_eth_cmac_rx_tx #(
  parameter int PKT_NUM         = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         udp_clk,
  input  logic         udp_reset,
  output logic         m_udp_config_valid,
  output logic [47:0]  m_udp_config_mac_addr,
  output logic [31:0]  m_udp_config_ip_addr,
  output logic [31:0]  m_udp_config_net_mask,
  output logic [31:0]  m_udp_config_gate_way,
  input  logic         m_udp_config_ready,
  output logic         m_udp_meta_valid,
  output logic [31:0]  m_udp_meta_ip_addr,
  output logic [5:0]   m_udp_meta_ip_dscp,
  output logic [1:0]   m_udp_meta_ip_ecn,
  output logic [15:0]  m_udp_meta_dst_port,
  output logic [15:0]  m_udp_meta_src_port,
  output logic [15:0]  m_udp_meta_data_len,
  input  logic         m_udp_meta_ready,
  output logic         m_data_stream_tvalid,
  output logic [255:0] m_data_stream_tdata,
  output logic [31:0]  m_data_stream_tkeep,
  output logic         m_data_stream_tfirst,
  output logic         m_data_stream_tlast,
  input  logic         m_data_stream_tready,
  input  logic         s_udp_meta_valid,
  input  logic [31:0]  s_udp_meta_ip_addr,
  input  logic [5:0]   s_udp_meta_ip_dscp,
  input  logic [1:0]   s_udp_meta_ip_ecn,
  input  logic [15:0]  s_udp_meta_dst_port,
  input  logic [15:0]  s_udp_meta_src_port,
  input  logic [15:0]  s_udp_meta_data_len,
  output logic         s_udp_meta_ready,
  input  logic         s_data_stream_tvalid,
  input  logic [255:0] s_data_stream_tdata,
  input  logic [31:0]  s_data_stream_tkeep,
  input  logic         s_data_stream_tfirst,
  input  logic         s_data_stream_tlast,
  output logic         s_data_stream_tready
);
  localparam logic [15:0] PKT_NUM_W = 16'(PKT_NUM);
  localparam logic [15:0] MAX_W     = 16'(MAX_OUTSTANDING);
  localparam logic [47:0] CFG_MAC   = 48'hD89C_679B_E3AA;
  localparam logic [31:0] CFG_IP    = 32'hC0A8_0001;
  localparam logic [31:0] CFG_MASK  = 32'hFFFF_FF00;
  localparam logic [31:0] CFG_GW    = 32'hC0A8_00FE;
  localparam logic [15:0] DST_PORT  = 16'h12B7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CONFIG = 3'd1, S_META = 3'd2, S_DATA = 3'd3, S_DONE = 3'd4
  } state_e;

  // Payload length of packet idx: ((idx mod 64) + 1) * 7 bytes.
  function automatic logic [15:0] pkt_len(input logic [15:0] idx);
    pkt_len = ((idx & 16'h003F) + 16'd1) * 16'd7;
  endfunction

  // Number of 32-byte beats needed for len bytes.
  function automatic logic [7:0] pkt_beats(input logic [15:0] len);
    pkt_beats = 8'((len + 16'd31) >> 5);
  endfunction

  // Byte enables of a beat: full except on the final beat, which keeps len mod 32 bytes.
  function automatic logic [31:0] beat_keep(input logic [15:0] len, input logic [7:0] beat);
    logic [4:0] rem;
    rem = 5'(len);
    if (beat != (pkt_beats(len) - 8'd1)) beat_keep = 32'hFFFF_FFFF;
    else if (rem == 5'd0)                beat_keep = 32'hFFFF_FFFF;
    else                                 beat_keep = ~(32'hFFFF_FFFF << rem);
  endfunction

  // Beat payload: lane j = (idx + 32*beat + j) mod 256, zero on lanes that are not kept.
  function automatic logic [255:0] beat_data(input logic [15:0] idx, input logic [7:0] beat,
                                             input logic [31:0] keep);
    logic [7:0] base;
    base = 8'(idx + {3'd0, beat, 5'd0});
    for (int j = 0; j < 32; j++) beat_data[j*8 +: 8] = keep[j] ? (base + 8'(j)) : 8'd0;
  endfunction

  // Expand per-byte enables into a per-bit mask.
  function automatic logic [255:0] byte_mask(input logic [31:0] keep);
    for (int j = 0; j < 32; j++) byte_mask[j*8 +: 8] = {8{keep[j]}};
  endfunction

  state_e state_q, state_d;
  logic [15:0] tx_idx_q, tx_idx_d, tx_sent_q, tx_sent_d;
  logic [7:0]  tx_beat_q, tx_beat_d;
  logic [15:0] rx_idx_q, rx_idx_d, rx_meta_idx_q, rx_meta_idx_d, err_cnt_q, err_cnt_d;
  logic [7:0]  rx_beat_q, rx_beat_d;
  logic        rx_ready_q;

  logic [15:0]  tx_len_s, rx_len_s, rx_cur_idx_s, meta_len_s;
  logic [31:0]  tx_keep_s, rx_keep_s;
  logic [255:0] tx_data_s, rx_data_s;
  logic [7:0]   rx_cur_beat_s;
  logic [16:0]  err_sum_s;
  logic tx_last_s, in_data_s, meta_go_s, cfg_hs_s, meta_hs_s, tx_hs_s;
  logic rx_meta_hs_s, rx_data_hs_s, rx_sync_s, rx_first_s, rx_last_s;
  logic meta_err_s, data_err_s, test_pass_s;

  // Current TX beat contents and the outstanding-packet gate for meta.
  always_comb begin
    tx_len_s  = pkt_len(tx_idx_q);
    tx_keep_s = beat_keep(tx_len_s, tx_beat_q);
    tx_last_s = (tx_beat_q == (pkt_beats(tx_len_s) - 8'd1));
    tx_data_s = beat_data(tx_idx_q, tx_beat_q, tx_keep_s);
    in_data_s = (state_q == S_DATA);
    // Once raised, this stays high: tx_sent_q is fixed in META and rx_idx_q only grows.
    meta_go_s = (state_q == S_META) && ((tx_sent_q - rx_idx_q) < MAX_W);
    cfg_hs_s  = m_udp_config_valid && m_udp_config_ready;
    meta_hs_s = m_udp_meta_valid && m_udp_meta_ready;
    tx_hs_s   = m_data_stream_tvalid && m_data_stream_tready;
  end

  assign m_udp_config_valid    = (state_q == S_CONFIG);
  assign m_udp_config_mac_addr = CFG_MAC;
  assign m_udp_config_ip_addr  = CFG_IP;
  assign m_udp_config_net_mask = CFG_MASK;
  assign m_udp_config_gate_way = CFG_GW;
  assign m_udp_meta_valid      = meta_go_s;
  assign m_udp_meta_ip_addr    = CFG_IP;
  assign m_udp_meta_ip_dscp    = 6'd0;
  assign m_udp_meta_ip_ecn     = 2'd0;
  assign m_udp_meta_dst_port   = DST_PORT;
  assign m_udp_meta_src_port   = tx_idx_q;
  assign m_udp_meta_data_len   = tx_len_s;
  assign m_data_stream_tvalid  = in_data_s;
  assign m_data_stream_tdata   = in_data_s ? tx_data_s : 256'd0;
  assign m_data_stream_tkeep   = in_data_s ? tx_keep_s : 32'd0;
  assign m_data_stream_tfirst  = in_data_s && (tx_beat_q == 8'd0);
  assign m_data_stream_tlast   = in_data_s && tx_last_s;
  assign s_udp_meta_ready      = rx_ready_q;
  assign s_data_stream_tready  = rx_ready_q;
  assign test_pass_s = (state_q == S_DONE) && (rx_idx_q == PKT_NUM_W) && (err_cnt_q == 16'd0);

  // TX state machine: next state, packet index, beat index and sent-meta count.
  always_comb begin
    state_d   = state_q;
    tx_idx_d  = tx_idx_q;
    tx_beat_d = tx_beat_q;
    tx_sent_d = tx_sent_q;
    case (state_q)
      S_IDLE: state_d = S_CONFIG;
      S_CONFIG: begin
        if (cfg_hs_s) state_d = S_META;
        else          state_d = S_CONFIG;
      end
      S_META: begin
        if (meta_hs_s) begin
          state_d   = S_DATA;
          tx_sent_d = tx_sent_q + 16'd1;
          tx_beat_d = 8'd0;
        end else begin
          state_d = S_META;
        end
      end
      S_DATA: begin
        if (tx_hs_s && tx_last_s) begin
          tx_beat_d = 8'd0;
          tx_idx_d  = tx_idx_q + 16'd1;
          if ((tx_idx_q + 16'd1) < PKT_NUM_W) state_d = S_META;
          else                                state_d = S_DONE;
        end else if (tx_hs_s) begin
          tx_beat_d = tx_beat_q + 8'd1;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // TX registers.
  always_ff @(posedge udp_clk or negedge udp_reset) begin
    if (!udp_reset) begin
      state_q   <= S_IDLE;
      tx_idx_q  <= 16'd0;
      tx_beat_q <= 8'd0;
      tx_sent_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      tx_idx_q  <= tx_idx_d;
      tx_beat_q <= tx_beat_d;
      tx_sent_q <= tx_sent_d;
    end
  end

  // RX checking: regenerate the expected beat/meta and flag mismatching handshakes.
  always_comb begin
    rx_meta_hs_s  = s_udp_meta_valid && rx_ready_q;
    rx_data_hs_s  = s_data_stream_tvalid && rx_ready_q;
    // A tfirst in the middle of a packet means tlast went missing: move on to the next packet.
    rx_sync_s     = s_data_stream_tfirst && (rx_beat_q != 8'd0);
    rx_cur_idx_s  = rx_sync_s ? (rx_idx_q + 16'd1) : rx_idx_q;
    rx_cur_beat_s = rx_sync_s ? 8'd0 : rx_beat_q;
    rx_len_s      = pkt_len(rx_cur_idx_s);
    rx_keep_s     = beat_keep(rx_len_s, rx_cur_beat_s);
    rx_data_s     = beat_data(rx_cur_idx_s, rx_cur_beat_s, rx_keep_s);
    rx_first_s    = (rx_cur_beat_s == 8'd0);
    rx_last_s     = (rx_cur_beat_s == (pkt_beats(rx_len_s) - 8'd1));
    data_err_s    = rx_data_hs_s && ((s_data_stream_tfirst != rx_first_s) ||
                    (s_data_stream_tlast != rx_last_s) || (s_data_stream_tkeep != rx_keep_s) ||
                    ((s_data_stream_tdata & byte_mask(rx_keep_s)) != rx_data_s));
    // Meta keeps its own index so a meta may run ahead of the data of the previous packet.
    meta_len_s    = pkt_len(rx_meta_idx_q);
    meta_err_s    = rx_meta_hs_s && ((s_udp_meta_ip_addr != CFG_IP) || (s_udp_meta_ip_dscp != 6'd0) ||
                    (s_udp_meta_ip_ecn != 2'd0) || (s_udp_meta_dst_port != DST_PORT) ||
                    (s_udp_meta_src_port != rx_meta_idx_q) || (s_udp_meta_data_len != meta_len_s));
    err_sum_s     = {1'b0, err_cnt_q} + {16'd0, meta_err_s} + {16'd0, data_err_s};
    err_cnt_d     = err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
    rx_idx_d      = rx_idx_q;
    rx_beat_d     = rx_beat_q;
    rx_meta_idx_d = rx_meta_idx_q;
    if (rx_data_hs_s && s_data_stream_tlast) begin
      rx_idx_d  = rx_cur_idx_s + 16'd1;
      rx_beat_d = 8'd0;
    end else if (rx_data_hs_s) begin
      rx_idx_d  = rx_cur_idx_s;
      rx_beat_d = rx_cur_beat_s + 8'd1;
    end else begin
      rx_beat_d = rx_beat_q;
    end
    if (rx_meta_hs_s) rx_meta_idx_d = rx_meta_idx_q + 16'd1;
    else              rx_meta_idx_d = rx_meta_idx_q;
  end

  // RX registers, error counter and the always-ready RX handshake.
  always_ff @(posedge udp_clk or negedge udp_reset) begin
    if (!udp_reset) begin
      rx_idx_q      <= 16'd0;
      rx_beat_q     <= 8'd0;
      rx_meta_idx_q <= 16'd0;
      err_cnt_q     <= 16'd0;
      rx_ready_q    <= 1'b0;
    end else begin
      rx_idx_q      <= rx_idx_d;
      rx_beat_q     <= rx_beat_d;
      rx_meta_idx_q <= rx_meta_idx_d;
      err_cnt_q     <= err_cnt_d;
      rx_ready_q    <= 1'b1;
    end
  end

`ifdef TEST_REPORT_EN
  // Simulation-only reporting of each mismatch and of the final verdict.
  always @(posedge udp_clk) begin
    if (udp_reset) begin
      if (meta_err_s)
        $display("pkt %0d meta: exp src %h len %0d, act ip %h dscp %0d ecn %0d dst %h src %h len %0d",
                 rx_meta_idx_q, rx_meta_idx_q, meta_len_s, s_udp_meta_ip_addr, s_udp_meta_ip_dscp,
                 s_udp_meta_ip_ecn, s_udp_meta_dst_port, s_udp_meta_src_port, s_udp_meta_data_len);
      if (data_err_s)
        $display("pkt %0d beat %0d data: exp first %b last %b keep %h data %h, act first %b last %b keep %h data %h",
                 rx_cur_idx_s, rx_cur_beat_s, rx_first_s, rx_last_s, rx_keep_s, rx_data_s,
                 s_data_stream_tfirst, s_data_stream_tlast, s_data_stream_tkeep, s_data_stream_tdata);
      if ((state_q == S_DONE) && (rx_idx_q == PKT_NUM_W)) begin
        if (err_cnt_q == 16'd0) $display("PASS");
        else                    $display("FAIL errors=%0d", err_cnt_q);
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mk_test_udp_ip_arp_eth_cmac_rx_tx.sv
// Testbench: the bench loops the TX side back into the RX side.
// A scoreboard checks every TX meta/beat against an independent packet model.
// The internal error counter shows the RX checker's verdict.
module tb_mk_test_udp_ip_arp_eth_cmac_rx_tx;
  localparam int PKT_NUM = 64;

  typedef struct packed {
    logic [31:0] ip; logic [5:0] dscp; logic [1:0] ecn;
    logic [15:0] dst; logic [15:0] src; logic [15:0] len;
  } meta_t;
  typedef struct packed {
    logic first; logic last; logic [31:0] keep; logic [255:0] data;
  } beat_t;

  logic udp_clk = 1'b0;
  logic udp_reset = 1'b1;
  logic m_udp_config_valid, m_udp_config_ready;
  logic [47:0] m_udp_config_mac_addr;
  logic [31:0] m_udp_config_ip_addr, m_udp_config_net_mask, m_udp_config_gate_way;
  logic m_udp_meta_valid, m_udp_meta_ready;
  logic [31:0] m_udp_meta_ip_addr; logic [5:0] m_udp_meta_ip_dscp; logic [1:0] m_udp_meta_ip_ecn;
  logic [15:0] m_udp_meta_dst_port, m_udp_meta_src_port, m_udp_meta_data_len;
  logic m_data_stream_tvalid, m_data_stream_tfirst, m_data_stream_tlast, m_data_stream_tready;
  logic [255:0] m_data_stream_tdata; logic [31:0] m_data_stream_tkeep;
  logic s_udp_meta_valid, s_udp_meta_ready;
  logic [31:0] s_udp_meta_ip_addr; logic [5:0] s_udp_meta_ip_dscp; logic [1:0] s_udp_meta_ip_ecn;
  logic [15:0] s_udp_meta_dst_port, s_udp_meta_src_port, s_udp_meta_data_len;
  logic s_data_stream_tvalid, s_data_stream_tfirst, s_data_stream_tlast, s_data_stream_tready;
  logic [255:0] s_data_stream_tdata; logic [31:0] s_data_stream_tkeep;

  always #5 udp_clk = ~udp_clk;

  mk_test_udp_ip_arp_eth_cmac_rx_tx #(.PKT_NUM(PKT_NUM), .MAX_OUTSTANDING(4)) dut (
    .udp_clk(udp_clk), .udp_reset(udp_reset),
    .m_udp_config_valid(m_udp_config_valid), .m_udp_config_mac_addr(m_udp_config_mac_addr),
    .m_udp_config_ip_addr(m_udp_config_ip_addr), .m_udp_config_net_mask(m_udp_config_net_mask),
    .m_udp_config_gate_way(m_udp_config_gate_way), .m_udp_config_ready(m_udp_config_ready),
    .m_udp_meta_valid(m_udp_meta_valid), .m_udp_meta_ip_addr(m_udp_meta_ip_addr),
    .m_udp_meta_ip_dscp(m_udp_meta_ip_dscp), .m_udp_meta_ip_ecn(m_udp_meta_ip_ecn),
    .m_udp_meta_dst_port(m_udp_meta_dst_port), .m_udp_meta_src_port(m_udp_meta_src_port),
    .m_udp_meta_data_len(m_udp_meta_data_len), .m_udp_meta_ready(m_udp_meta_ready),
    .m_data_stream_tvalid(m_data_stream_tvalid), .m_data_stream_tdata(m_data_stream_tdata),
    .m_data_stream_tkeep(m_data_stream_tkeep), .m_data_stream_tfirst(m_data_stream_tfirst),
    .m_data_stream_tlast(m_data_stream_tlast), .m_data_stream_tready(m_data_stream_tready),
    .s_udp_meta_valid(s_udp_meta_valid), .s_udp_meta_ip_addr(s_udp_meta_ip_addr),
    .s_udp_meta_ip_dscp(s_udp_meta_ip_dscp), .s_udp_meta_ip_ecn(s_udp_meta_ip_ecn),
    .s_udp_meta_dst_port(s_udp_meta_dst_port), .s_udp_meta_src_port(s_udp_meta_src_port),
    .s_udp_meta_data_len(s_udp_meta_data_len), .s_udp_meta_ready(s_udp_meta_ready),
    .s_data_stream_tvalid(s_data_stream_tvalid), .s_data_stream_tdata(s_data_stream_tdata),
    .s_data_stream_tkeep(s_data_stream_tkeep), .s_data_stream_tfirst(s_data_stream_tfirst),
    .s_data_stream_tlast(s_data_stream_tlast), .s_data_stream_tready(s_data_stream_tready)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cfg_hs = 0, metas_sent = 0, beats_sent = 0, tx_pkt = 0, tx_beat = 0;
  bit corrupt_en = 1'b0, rx_pause = 1'b0;
  meta_t exp_meta_q[$], loop_meta_q[$];
  beat_t exp_beat_q[$], loop_beat_q[$];
  meta_t mon_m, mon_em, rm;
  beat_t mon_b, mon_eb, lb, rb;

  // Count one comparison and report it when observed and expected differ.
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] out_vec();
    out_vec = 512'({m_udp_config_valid, m_udp_meta_valid, m_data_stream_tvalid, m_data_stream_tfirst,
                    m_data_stream_tlast, m_data_stream_tkeep, m_data_stream_tdata,
                    s_udp_meta_ready, s_data_stream_tready});
  endfunction

  function automatic logic [511:0] cfg_vec();
    cfg_vec = 512'({m_udp_config_mac_addr, m_udp_config_ip_addr, m_udp_config_net_mask, m_udp_config_gate_way});
  endfunction

  function automatic meta_t meta_now();
    meta_now = '{m_udp_meta_ip_addr, m_udp_meta_ip_dscp, m_udp_meta_ip_ecn,
                 m_udp_meta_dst_port, m_udp_meta_src_port, m_udp_meta_data_len};
  endfunction

  // Reference packet model: byte offset within the packet runs 0..len-1.
  task automatic fill_expected();
    meta_t m; beat_t b; int len, n;
    exp_meta_q.delete(); exp_beat_q.delete();
    for (int i = 0; i < PKT_NUM; i++) begin
      len = ((i % 64) + 1) * 7;
      m = '{32'hC0A8_0001, 6'd0, 2'd0, 16'h12B7, 16'(i), 16'(len)};
      exp_meta_q.push_back(m);
      for (int off = 0; off < len; off += 32) begin
        n = (len - off > 32) ? 32 : len - off;
        b = '0;
        b.first = (off == 0);
        b.last  = (off + 32 >= len);
        for (int j = 0; j < n; j++) begin
          b.keep[j] = 1'b1;
          b.data[j*8 +: 8] = 8'((i + off + j) % 256);
        end
        exp_beat_q.push_back(b);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge udp_clk); #2;
    udp_reset = 1'b0;
    exp_meta_q.delete(); exp_beat_q.delete(); loop_meta_q.delete(); loop_beat_q.delete();
    metas_sent = 0; beats_sent = 0; tx_pkt = 0; tx_beat = 0;
    #1;
  endtask

  task automatic release_reset();
    repeat (3) @(negedge udp_clk);
    udp_reset = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (dut.rx_idx_q != 16'd64 && cyc < 20000) begin @(negedge udp_clk); cyc++; end
    chk(tag, 512'(cyc < 20000), 512'(1));
    repeat (4) @(negedge udp_clk);
  endtask

  // TX monitor/scoreboard: handshakes seen at the negedge complete at the next posedge.
  always @(negedge udp_clk) begin
    if (udp_reset) begin
      if (m_udp_config_valid && m_udp_config_ready) cfg_hs++;
      if (m_udp_meta_valid && m_udp_meta_ready) begin
        mon_m  = meta_now();
        mon_em = (exp_meta_q.size() > 0) ? exp_meta_q.pop_front() : '0;
        chk("tx_meta", 512'(mon_m), 512'(mon_em));
        loop_meta_q.push_back(mon_m);
        metas_sent++;
      end
      if (m_data_stream_tvalid && m_data_stream_tready) begin
        mon_b  = '{m_data_stream_tfirst, m_data_stream_tlast, m_data_stream_tkeep, m_data_stream_tdata};
        mon_eb = (exp_beat_q.size() > 0) ? exp_beat_q.pop_front() : '0;
        chk("tx_beat", 512'(mon_b), 512'(mon_eb));
        if (tx_pkt == 4 && tx_beat == 1) begin
          chk("p4_b1_keep", 512'(m_data_stream_tkeep), 512'(32'h0000_0007));
          chk("p4_b1_byte0", 512'(m_data_stream_tdata[7:0]), 512'(8'h24));
        end
        lb = mon_b;
        if (corrupt_en && tx_pkt == 10 && tx_beat == 0) lb.data[47:40] = lb.data[47:40] ^ 8'h01;
        loop_beat_q.push_back(lb);
        beats_sent++;
        if (m_data_stream_tlast) begin tx_pkt++; tx_beat = 0; end
        else tx_beat++;
      end
    end
  end

  // RX loopback driver: replays captured TX traffic into the RX ports.
  initial begin
    s_udp_meta_valid = 1'b0; s_udp_meta_ip_addr = 32'd0; s_udp_meta_ip_dscp = 6'd0;
    s_udp_meta_ip_ecn = 2'd0; s_udp_meta_dst_port = 16'd0; s_udp_meta_src_port = 16'd0;
    s_udp_meta_data_len = 16'd0; s_data_stream_tvalid = 1'b0; s_data_stream_tdata = 256'd0;
    s_data_stream_tkeep = 32'd0; s_data_stream_tfirst = 1'b0; s_data_stream_tlast = 1'b0;
    forever begin
      @(negedge udp_clk);
      if (!udp_reset) begin
        s_udp_meta_valid = 1'b0;
        s_data_stream_tvalid = 1'b0;
      end else begin
        if (s_udp_meta_valid) void'(loop_meta_q.pop_front());
        if (s_data_stream_tvalid) void'(loop_beat_q.pop_front());
        s_udp_meta_valid = 1'b0;
        s_data_stream_tvalid = 1'b0;
        if (!rx_pause && s_udp_meta_ready && loop_meta_q.size() > 0) begin
          rm = loop_meta_q[0];
          {s_udp_meta_ip_addr, s_udp_meta_ip_dscp, s_udp_meta_ip_ecn, s_udp_meta_dst_port,
           s_udp_meta_src_port, s_udp_meta_data_len} = rm;
          s_udp_meta_valid = 1'b1;
        end
        if (!rx_pause && s_data_stream_tready && loop_beat_q.size() > 0) begin
          rb = loop_beat_q[0];
          {s_data_stream_tfirst, s_data_stream_tlast, s_data_stream_tkeep, s_data_stream_tdata} = rb;
          s_data_stream_tvalid = 1'b1;
        end
      end
    end
  end

  initial begin
    meta_t snap;
    int cfg_before, cyc;
    m_udp_config_ready = 1'b1; m_udp_meta_ready = 1'b0; m_data_stream_tready = 1'b1;
    #1 udp_reset = 1'b0;
    repeat (3) @(posedge udp_clk); #1;
    chk("reset_outputs", out_vec(), 512'(0));

    // Config once, then meta held back by meta_ready=0.
    fill_expected();
    @(negedge udp_clk); udp_reset = 1'b1; #1;
    chk("idle_no_cfg_valid", 512'(m_udp_config_valid), 512'(0));
    @(posedge udp_clk); #1;
    chk("cfg_valid_after_idle", 512'(m_udp_config_valid), 512'(1));
    chk("cfg_values", cfg_vec(), 512'({48'hD89C_679B_E3AA, 32'hC0A8_0001, 32'hFFFF_FF00, 32'hC0A8_00FE}));
    repeat (20) @(posedge udp_clk); #1;
    snap = meta_now();
    chk("meta_wait_valid", 512'(m_udp_meta_valid), 512'(1));
    chk("meta_wait_p0", 512'(snap), 512'(exp_meta_q[0]));
    repeat (20) @(posedge udp_clk); #1;
    chk("meta_wait_still_valid", 512'(m_udp_meta_valid), 512'(1));
    chk("meta_wait_stable", 512'(meta_now()), 512'(snap));
    chk("meta_wait_no_beats", 512'(beats_sent), 512'(0));
    chk("cfg_once_early", 512'(cfg_hs), 512'(1));

    // Ideal loopback of all packets.
    m_udp_meta_ready = 1'b1;
    wait_done("loopback_done");
    chk("loopback_errs", 512'(dut.err_cnt_q), 512'(0));
    chk("loopback_pass", 512'(dut.test_pass_s), 512'(1));
    chk("loopback_metas", 512'(metas_sent), 512'(64));
    chk("loopback_exp_left", 512'(exp_meta_q.size() + exp_beat_q.size()), 512'(0));
    chk("cfg_once_total", 512'(cfg_hs), 512'(1));

    // One corrupted RX byte in packet 10.
    do_reset();
    corrupt_en = 1'b1;
    fill_expected();
    release_reset();
    wait_done("corrupt_done");
    chk("corrupt_errs", 512'(dut.err_cnt_q), 512'(1));
    chk("corrupt_no_pass", 512'(dut.test_pass_s), 512'(0));
    corrupt_en = 1'b0;

    // RX stalled: outstanding limit, then reset mid-packet.
    do_reset();
    rx_pause = 1'b1;
    fill_expected();
    release_reset();
    repeat (300) @(posedge udp_clk); #1;
    chk("stall_metas", 512'(metas_sent), 512'(4));
    chk("stall_beats", 512'(beats_sent), 512'(4));
    chk("stall_meta_blocked", 512'(m_udp_meta_valid), 512'(0));
    rx_pause = 1'b0;
    cyc = 0;
    while (!(tx_pkt == 5 && tx_beat == 1) && cyc < 2000) begin @(posedge udp_clk); cyc++; end
    chk("reach_mid_pkt5", 512'(cyc < 2000), 512'(1));
    cfg_before = cfg_hs;
    do_reset();
    chk("midrst_outputs", out_vec(), 512'(0));
    chk("midrst_counters", 512'({dut.rx_idx_q, dut.err_cnt_q, dut.tx_idx_q}), 512'(0));
    fill_expected();
    release_reset();
    @(posedge udp_clk); #1;
    chk("cfg_resent_valid", 512'(m_udp_config_valid), 512'(1));
    chk("cfg_resent_values", cfg_vec(), 512'({48'hD89C_679B_E3AA, 32'hC0A8_0001, 32'hFFFF_FF00, 32'hC0A8_00FE}));
    wait_done("restart_done");
    chk("cfg_resent_once", 512'(cfg_hs - cfg_before), 512'(1));
    chk("restart_pass", 512'(dut.test_pass_s), 512'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
